// File: rtl/down_count_monitor.sv
// Health monitor for a down counter: checks each sampled value is one below the previous (mod 2^WIDTH),
// reporting lock, wrap and step errors plus saturating wrap/error statistics.
module down_count_monitor #(
   parameter int WIDTH     = 4,
   parameter int ERR_LIMIT = 3,
   parameter int STAT_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  cnt_in,
   input  logic              cnt_valid,
   input  logic              clr_fault,
   output logic              locked,
   output logic              fault,
   output logic              step_err,
   output logic              wrap_pulse,
   output logic [STAT_W-1:0] wrap_count,
   output logic [STAT_W-1:0] err_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [3:0] ERR_LIM_C = 4'(ERR_LIMIT);

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    prev_q, prev_d;
   logic [3:0]          consec_q, consec_d;
   logic                locked_q, locked_d;
   logic                step_err_q, step_err_d;
   logic                wrap_pulse_q, wrap_pulse_d;
   logic [STAT_W-1:0]   wrap_count_q, wrap_count_d;
   logic [STAT_W-1:0]   err_count_q, err_count_d;
   logic [WIDTH-1:0]    exp_val;
   logic [3:0]          consec_inc;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   always_comb begin
      state_d      = state_q;
      prev_d       = prev_q;
      consec_d     = consec_q;
      locked_d     = locked_q;
      step_err_d   = 1'b0;
      wrap_pulse_d = 1'b0;
      wrap_count_d = wrap_count_q;
      err_count_d  = err_count_q;
      exp_val      = prev_q - 1'b1;
      consec_inc   = consec_q + 4'd1;

      case (state_q)
         IDLE: begin
            locked_d = 1'b0;
            if (cnt_valid) begin
               // First sample after acquire only seeds prev; nothing to compare against yet.
               prev_d  = cnt_in;
               state_d = TRACK;
            end
         end
         TRACK: begin
            if (cnt_valid) begin
               prev_d = cnt_in;
               if (cnt_in == exp_val) begin
                  locked_d = 1'b1;
                  consec_d = 4'd0;
                  if (prev_q == '0) begin
                     wrap_pulse_d = 1'b1;
                     wrap_count_d = sat_inc(wrap_count_q);
                  end
               end else begin
                  step_err_d  = 1'b1;
                  err_count_d = sat_inc(err_count_q);
                  locked_d    = 1'b0;
                  consec_d    = consec_inc;
                  if (consec_inc == ERR_LIM_C) state_d = FAULT;
               end
            end else begin
               // Stall: prev is kept but the next sample is a fresh acquire.
               state_d  = IDLE;
               locked_d = 1'b0;
               consec_d = 4'd0;
            end
         end
         FAULT: begin
            locked_d = 1'b0;
            if (clr_fault) begin
               state_d  = IDLE;
               consec_d = 4'd0;
            end
         end
         default: begin
            state_d  = IDLE;
            locked_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         prev_q       <= '0;
         consec_q     <= 4'd0;
         locked_q     <= 1'b0;
         step_err_q   <= 1'b0;
         wrap_pulse_q <= 1'b0;
         wrap_count_q <= '0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         consec_q     <= consec_d;
         locked_q     <= locked_d;
         step_err_q   <= step_err_d;
         wrap_pulse_q <= wrap_pulse_d;
         wrap_count_q <= wrap_count_d;
         err_count_q  <= err_count_d;
      end
   end

   assign locked     = locked_q;
   assign fault      = (state_q == FAULT);
   assign step_err   = step_err_q;
   assign wrap_pulse = wrap_pulse_q;
   assign wrap_count = wrap_count_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_down_count_monitor.sv
// Scoreboard bench for down_count_monitor: directed vectors push expected outputs,
// a monitor pops and compares one entry per clock after the sampling edge.
module tb_down_count_monitor;

   typedef struct packed {
      logic       l;
      logic       f;
      logic       se;
      logic       wp;
      logic [1:0] wc;
      logic [1:0] ec;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] cnt_in;
   logic       cnt_valid;
   logic       clr_fault;
   logic       locked;
   logic       fault;
   logic       step_err;
   logic       wrap_pulse;
   logic [1:0] wrap_count;
   logic [1:0] err_count;

   exp_t  exp_q[$];
   string name_q[$];
   int    tests  = 0;
   int    failed = 0;
   logic [1:0] m_wc = 2'd0;
   logic [1:0] m_ec = 2'd0;

   always #5 clk = ~clk;

   down_count_monitor #(.WIDTH(4), .ERR_LIMIT(3), .STAT_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .cnt_in     (cnt_in),
      .cnt_valid  (cnt_valid),
      .clr_fault  (clr_fault),
      .locked     (locked),
      .fault      (fault),
      .step_err   (step_err),
      .wrap_pulse (wrap_pulse),
      .wrap_count (wrap_count),
      .err_count  (err_count)
   );

   // Monitor: outputs are registered, so each pushed entry is due just after the next rising edge.
   initial begin
      exp_t  e;
      exp_t  act;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = '{locked, fault, step_err, wrap_pulse, wrap_count, err_count};
            tests++;
            if (act !== e) begin
               failed++;
               $display("FAIL %s: got l/f/se/wp/wc/ec=%b/%b/%b/%b/%0d/%0d want %b/%b/%b/%b/%0d/%0d",
                        nm, act.l, act.f, act.se, act.wp, act.wc, act.ec,
                        e.l, e.f, e.se, e.wp, e.wc, e.ec);
            end
         end
      end
   end

   task automatic cyc(input logic r, input logic v, input logic [3:0] c, input logic clr,
                      input logic l, input logic f, input logic se, input logic wp,
                      input string nm);
      @(negedge clk);
      rst       = r;
      cnt_valid = v;
      cnt_in    = c;
      clr_fault = clr;
      if (r) begin
         m_wc = 2'd0;
         m_ec = 2'd0;
      end else begin
         if (wp && m_wc != 2'd3) m_wc = m_wc + 2'd1;
         if (se && m_ec != 2'd3) m_ec = m_ec + 2'd1;
      end
      exp_q.push_back('{l, f, se, wp, m_wc, m_ec});
      name_q.push_back(nm);
   endtask

   initial begin
      rst = 1'b1; cnt_valid = 1'b0; cnt_in = 4'd0; clr_fault = 1'b0;

      cyc(1, 0, 0, 0, 0, 0, 0, 0, "reset");

      // Clean run: 15..0,15..0,15
      for (int i = 0; i < 33; i++)
         cyc(0, 1, 4'(15 - (i % 16)), 0, i >= 1, 0, 0, (i == 16) || (i == 32), "clean");
      cyc(0, 0, 0, 0, 0, 0, 0, 0, "clean_stop");
      cyc(1, 0, 0, 0, 0, 0, 0, 0, "reset");

      // Single glitch: 9,8,5,4,3
      cyc(0, 1, 9, 0, 0, 0, 0, 0, "glitch_acq");
      cyc(0, 1, 8, 0, 1, 0, 0, 0, "glitch_lock");
      cyc(0, 1, 5, 0, 0, 0, 1, 0, "glitch_err");
      cyc(0, 1, 4, 0, 1, 0, 0, 0, "glitch_relock");
      cyc(0, 1, 3, 0, 1, 0, 0, 0, "glitch_hold");
      cyc(1, 0, 0, 0, 0, 0, 0, 0, "reset");

      // Fault entry: 7,7,7,7 then a sample in FAULT, clear, reacquire 6,5 with clr_fault ignored
      cyc(0, 1, 7, 0, 0, 0, 0, 0, "fault_acq");
      cyc(0, 1, 7, 0, 0, 0, 1, 0, "fault_err1");
      cyc(0, 1, 7, 0, 0, 0, 1, 0, "fault_err2");
      cyc(0, 1, 7, 0, 0, 1, 1, 0, "fault_err3");
      cyc(0, 1, 7, 0, 0, 1, 0, 0, "fault_ignore");
      cyc(0, 0, 0, 1, 0, 0, 0, 0, "fault_clr");
      cyc(0, 1, 6, 1, 0, 0, 0, 0, "fault_reacq");
      cyc(0, 1, 5, 1, 1, 0, 0, 0, "fault_relock");
      cyc(1, 0, 0, 0, 0, 0, 0, 0, "reset");

      // Stall reacquire: 4,3, stall 2 cycles, 12,11
      cyc(0, 1, 4,  0, 0, 0, 0, 0, "stall_acq");
      cyc(0, 1, 3,  0, 1, 0, 0, 0, "stall_lock");
      cyc(0, 0, 2,  0, 0, 0, 0, 0, "stall_1");
      cyc(0, 0, 1,  0, 0, 0, 0, 0, "stall_2");
      cyc(0, 1, 12, 0, 0, 0, 0, 0, "stall_reacq");
      cyc(0, 1, 11, 0, 1, 0, 0, 0, "stall_relock");
      cyc(1, 0, 0,  0, 0, 0, 0, 0, "reset");

      // Saturation: five legal wraps with a 2-bit wrap counter
      for (int i = 0; i < 81; i++)
         cyc(0, 1, 4'(15 - (i % 16)), 0, i >= 1, 0, 0, (i > 0) && (i % 16 == 0), "sat");
      cyc(0, 0, 0, 0, 0, 0, 0, 0, "sat_stop");

      // Reset priority over clr_fault while in FAULT
      cyc(0, 1, 7, 0, 0, 0, 0, 0, "rp_acq");
      cyc(0, 1, 7, 0, 0, 0, 1, 0, "rp_err1");
      cyc(0, 1, 7, 0, 0, 0, 1, 0, "rp_err2");
      cyc(0, 1, 7, 0, 0, 1, 1, 0, "rp_err3");
      cyc(1, 1, 7, 1, 0, 0, 0, 0, "rp_rst_clr");
      cyc(0, 1, 2, 0, 0, 0, 0, 0, "rp_acq2");
      cyc(0, 1, 1, 0, 1, 0, 0, 0, "rp_lock");
      // Reset while locked; a sample of 0 then 15 would look like a wrap if compared
      cyc(1, 1, 0,  0, 0, 0, 0, 0, "rp_rst_locked");
      cyc(0, 1, 15, 0, 0, 0, 0, 0, "rp_fresh");
      cyc(0, 1, 14, 0, 1, 0, 0, 0, "rp_relock");
      cyc(0, 0, 0,  0, 0, 0, 0, 0, "rp_stop");

      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         tests++;
         failed++;
         $display("FAIL drain: got %0d entries pending, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
